// File: rtl/pchri03_pattern_matcher_if.sv
// Byte-wide TinyTapeout pin bundle for the pattern matcher tile.
// The host drives the master side and the tile presents the slave side.
interface pchri03_pattern_matcher_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/pchri03_pattern_matcher.sv
// Chip-select framed command port feeding an 8-slot programmable
// sequence matcher with current-match and sticky match vectors.
module pchri03_pattern_matcher (
    input  logic                       clk,
    input  logic                       rst_n,
    pchri03_pattern_matcher_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_CMD,
        ST_W_ADDR,
        ST_W_DATA,
        ST_R_ADDR,
        ST_S_DATA
    } state_e;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STREAM = 8'h80;
    localparam logic [7:0] A_STICKY  = 8'h10;
    localparam logic [7:0] A_ACT     = 8'h11;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] char_q [8];
    logic [7:0] char_d [8];
    logic [7:0] pred_q [8];
    logic [7:0] pred_d [8];
    logic [7:0] act_q, act_d;
    logic [7:0] sticky_q, sticky_d;
    logic [7:0] rdata_q, rdata_d;

    logic       cs_n;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic       st_en;
    logic [7:0] p_vec;
    logic [7:0] hit;
    logic       unused_ok;

    assign cs_n = bus.uio_in[0];
    assign din  = bus.ui_in;

    assign bus.uo_out  = rdata_q;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    assign unused_ok = &{1'b0, bus.ena, bus.uio_in[7:1]};

    // Bit 0 is the start token, so slots with PRED bit 0 can open a chain.
    assign p_vec = {act_q[6:0], 1'b1};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hit[i] = (char_q[i] == din) && ((pred_q[i] & p_vec) != 8'h00);
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        st_en   = 1'b0;
        if (cs_n) begin
            state_d = ST_CMD;
        end else begin
            unique case (state_q)
                ST_CMD: begin
                    unique case (din)
                        OP_WRITE:  state_d = ST_W_ADDR;
                        OP_READ:   state_d = ST_R_ADDR;
                        OP_STREAM: state_d = ST_S_DATA;
                        default:   state_d = ST_CMD;
                    endcase
                end
                ST_W_ADDR: state_d = ST_W_DATA;
                ST_W_DATA: begin
                    wr_en   = 1'b1;
                    state_d = ST_CMD;
                end
                ST_R_ADDR: begin
                    rd_en   = 1'b1;
                    state_d = ST_CMD;
                end
                ST_S_DATA: begin
                    st_en   = 1'b1;
                    state_d = ST_CMD;
                end
                default: state_d = ST_CMD;
            endcase
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (!cs_n && state_q == ST_W_ADDR) begin
            addr_d = din;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            char_d[i] = char_q[i];
            pred_d[i] = pred_q[i];
        end
        act_d    = act_q;
        sticky_d = sticky_q;
        if (wr_en) begin
            if (addr_q[7:3] == 5'b00000) begin
                char_d[addr_q[2:0]] = din;
            end else if (addr_q[7:3] == 5'b00001) begin
                pred_d[addr_q[2:0]] = din;
            end else if (addr_q == A_STICKY) begin
                act_d    = 8'h00;
                sticky_d = 8'h00;
            end
        end else if (st_en) begin
            act_d    = hit;
            sticky_d = sticky_q | hit;
        end
    end

    // The read address is the live byte; the result lands one edge later.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            if (din[7:3] == 5'b00000) begin
                rdata_d = char_q[din[2:0]];
            end else if (din[7:3] == 5'b00001) begin
                rdata_d = pred_q[din[2:0]];
            end else if (din == A_STICKY) begin
                rdata_d = sticky_q;
            end else if (din == A_ACT) begin
                rdata_d = act_q;
            end else begin
                rdata_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CMD;
            addr_q   <= 8'h00;
            act_q    <= 8'h00;
            sticky_q <= 8'h00;
            rdata_q  <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                char_q[i] <= 8'h00;
                pred_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            act_q    <= act_d;
            sticky_q <= sticky_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < 8; i++) begin
                char_q[i] <= char_d[i];
                pred_q[i] <= pred_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pchri03_pattern_matcher.sv
// Randomized bench for the pattern matcher tile against a
// transaction-level model of its register map and matching rule.
module tb_pchri03_pattern_matcher;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pchri03_pattern_matcher_if bus ();

    pchri03_pattern_matcher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] m_char [8];
    logic [7:0] m_pred [8];
    logic [7:0] m_act;
    logic [7:0] m_sticky;
    logic [7:0] m_rdata;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_char[i] = 8'h00;
            m_pred[i] = 8'h00;
        end
        m_act    = 8'h00;
        m_sticky = 8'h00;
        m_rdata  = 8'h00;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a < 8'd8)       return m_char[a[2:0]];
        else if (a < 8'd16) return m_pred[a[2:0]];
        else if (a == 8'h10) return m_sticky;
        else if (a == 8'h11) return m_act;
        else                 return 8'h00;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (a < 8'd8) m_char[a[2:0]] = d;
        else if (a < 8'd16) m_pred[a[2:0]] = d;
        else if (a == 8'h10) begin
            m_act    = 8'h00;
            m_sticky = 8'h00;
        end
    endtask

    // Slot i fires if its char matches and any enabled predecessor is live:
    // predecessor 0 is the start token, predecessor k is slot k-1.
    task automatic m_stream(input logic [7:0] c);
        logic [7:0] nxt;
        nxt = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_char[i] == c) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_pred[i][k] && (k == 0 || m_act[k-1]))
                        nxt[i] = 1'b1;
                end
            end
        end
        m_act    = nxt;
        m_sticky = m_sticky | nxt;
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        r = 8'($urandom);
        bus.uio_in = {r[7:1], 1'b0};
        bus.ui_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic cs_high();
        logic [7:0] r;
        r = 8'($urandom);
        bus.uio_in = {r[7:1], 1'b1};
        bus.ui_in  = 8'($urandom);
        @(posedge clk);
        #1;
        chk("hold", bus.uo_out, m_rdata);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send(8'h02);
        send(a);
        send(d);
        m_write(a, d);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a);
        send(8'h03);
        send(a);
        m_rdata = m_read(a);
        chk(tag, bus.uo_out, m_rdata);
    endtask

    task automatic do_stream(input logic [7:0] c);
        send(8'h80);
        send(c);
        m_stream(c);
    endtask

    task automatic program_chain();
        do_write(8'h00, 8'h61);
        do_write(8'h01, 8'h62);
        do_write(8'h02, 8'h63);
        for (int a = 3; a < 8; a++) do_write(8'(a), 8'h00);
        do_write(8'h08, 8'h01);
        do_write(8'h09, 8'h02);
        do_write(8'h0A, 8'h04);
        for (int a = 11; a < 16; a++) do_write(8'(a), 8'h00);
    endtask

    task automatic rand_op();
        int         op;
        int         r;
        logic [7:0] a;
        logic [7:0] d;
        op = $urandom_range(0, 9);
        case (op)
            0, 1: begin
                r = $urandom_range(0, 19);
                if (r < 16) a = 8'(r);
                else if (r < 18) a = 8'h10;
                else a = 8'($urandom_range(17, 255));
                if (a < 8'd8) d = 8'($urandom_range(8'h61, 8'h64));
                else d = 8'($urandom);
                do_write(a, d);
            end
            2, 3: begin
                r = $urandom_range(0, 21);
                a = (r < 20) ? 8'(r) : 8'($urandom);
                do_read("rd_rand", a);
            end
            4, 5, 6: do_stream(8'($urandom_range(8'h61, 8'h64)));
            7: begin
                d = 8'($urandom);
                if (d == 8'h02 || d == 8'h03 || d == 8'h80) d = 8'h55;
                send(d);
            end
            8: begin
                r = $urandom_range(0, 3);
                case (r)
                    0: send(8'h02);
                    1: begin send(8'h02); send(8'($urandom_range(0, 16))); end
                    2: send(8'h03);
                    default: send(8'h80);
                endcase
                cs_high();
            end
            default: begin
                cs_high();
                chk("uio_oe", bus.uio_oe, 8'h00);
                chk("uio_out", bus.uio_out, 8'h00);
            end
        endcase
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h01;
        rst_n      = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uo", bus.uo_out, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_read("s1_rd05", 8'h05);
        chk("s1_uio_oe", bus.uio_oe, 8'h00);
        chk("s1_uio_out", bus.uio_out, 8'h00);
        cs_high();

        program_chain();
        cs_high();
        do_stream(8'h61);
        do_stream(8'h62);
        do_stream(8'h63);
        do_stream(8'h64);
        cs_high();
        do_read("s2_sticky", 8'h10);
        chk("s2_sticky_lit", bus.uo_out, 8'h07);
        do_read("s2_act", 8'h11);
        chk("s2_act_lit", bus.uo_out, 8'h00);
        cs_high();

        do_write(8'h10, 8'h00);
        do_stream(8'h61);
        do_stream(8'h63);
        cs_high();
        do_read("s3_sticky", 8'h10);
        chk("s3_sticky_lit", bus.uo_out, 8'h01);
        cs_high();

        do_write(8'h10, 8'h00);
        do_stream(8'h62);
        cs_high();
        do_read("s4_sticky", 8'h10);
        chk("s4_sticky_lit", bus.uo_out, 8'h00);
        cs_high();

        do_stream(8'h61);
        do_stream(8'h62);
        do_stream(8'h63);
        do_read("s5_pre", 8'h10);
        chk("s5_pre_lit", bus.uo_out, 8'h07);
        do_write(8'h10, 8'hFF);
        do_read("s5_clr", 8'h10);
        chk("s5_clr_lit", bus.uo_out, 8'h00);
        send(8'h02);
        send(8'h00);
        cs_high();
        do_read("s5_keep", 8'h00);
        chk("s5_keep_lit", bus.uo_out, 8'h61);
        cs_high();

        do_stream(8'h61);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("s6_async", bus.uo_out, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read("s6_sticky", 8'h10);
        chk("s6_sticky_lit", bus.uo_out, 8'h00);
        do_read("s6_char0", 8'h00);
        chk("s6_char0_lit", bus.uo_out, 8'h00);
        cs_high();

        program_chain();
        for (int n = 0; n < 600; n++) rand_op();
        cs_high();
        for (int a = 0; a < 18; a++) do_read("final", 8'(a));
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
